mem_bus_arbiter: RTL and testbench

Round-robin arbiter for the shared memory interconnect. Requesters are the icache, the dcache, the page walker and DMA. It grants the bus to one requester at a time and holds the grant while the owner keeps its busy line high. It muxes the owner's address and command onto the bus and steers `mem_data_valid` back to the owner only. It replaces the daisy-chained `grant_in`/`grant_out` scheme with a central scheduler between the cache controllers and the bus.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 40 ++++
 rtl/mem_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the memory-bus round-robin arbiter.
package mem_arb_pkg;

   localparam int NREQ_DEF     = 4;
   localparam int BUSADDRW_DEF = 32;
   localparam int IDW_DEF      = 2;
   localparam int ACK_WAIT_DEF = 4;
   localparam int MAX_HOLD_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_OWNED   = 2'd2,
      ST_RELEASE = 2'd3
   } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: rotate the request vector so the slot after
// ptr sits at bit 0, priority-encode the lowest set bit, then rotate back.
module rr_pick
   import mem_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IDW  = IDW_DEF
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [IDW-1:0]  win,
   output logic            any_req
);

   logic [NREQ-1:0] rot;
   logic [IDW-1:0]  off;
   logic            found;

   // rot[i] holds the requester that sits i+1 places after ptr
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         rot[i] = req[IDW'((32'(ptr) + 32'(i) + 32'd1) % 32'(NREQ))];
      end
   end

   always_comb begin
      found = 1'b0;
      off   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            off   = IDW'(i);
         end
      end
   end

   assign any_req = |req;
   assign win     = IDW'((32'(ptr) + 32'(off) + 32'd1) % 32'(NREQ));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Central round-robin arbiter for the shared memory bus (IDLE/GRANT/OWNED/RELEASE).
// Optional ownership timeout is built only when MEM_ARB_TIMEOUT_EN is defined.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NREQ     = NREQ_DEF,
   parameter int BUSADDRW = BUSADDRW_DEF,
   parameter int IDW      = IDW_DEF,
   parameter int ACK_WAIT = ACK_WAIT_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          busy,
   input  logic [NREQ*BUSADDRW-1:0] req_addr,
   input  logic [NREQ-1:0]          req_rd_wr,
   output logic [NREQ-1:0]          grant,
   output logic [IDW-1:0]           owner_id,
   output logic [BUSADDRW-1:0]      mem_addr,
   output logic                     mem_rd_wr,
   output logic                     mem_en,
   input  logic                     mem_data_valid,
   output logic [NREQ-1:0]          data_valid,
   output logic                     timeout_err,
   output logic [1:0]               state_dbg
);

   // Handshake: a requester holds req until granted; it then owns the bus
   // from the cycle after it raises busy until the cycle busy is seen low.
   localparam int WAIT_W = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;

   arb_state_e        state, state_nxt;
   logic [NREQ-1:0]   grant_nxt;
   logic [IDW-1:0]    owner_nxt;
   logic [IDW-1:0]    ptr, ptr_nxt;
   logic [IDW-1:0]    win;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic              any_req;
   logic              owner_busy;
   logic              owner_req;
   logic              hold_expired;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req     (req),
      .ptr     (ptr),
      .win     (win),
      .any_req (any_req)
   );

   assign owner_busy = busy[owner_id];
   assign owner_req  = req[owner_id];

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   logic [HOLD_W-1:0] hold_cnt;
   logic              timeout_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_cnt <= '0;
      end else if (state != ST_OWNED) begin
         hold_cnt <= '0;
      end else begin
         hold_cnt <= hold_cnt + HOLD_W'(1);
      end
   end

   // A normal busy drop on the final cycle wins over the forced revoke.
   assign hold_expired = (state == ST_OWNED) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
   assign timeout_nxt  = hold_expired && owner_busy;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= timeout_nxt;
      end
   end
`else
   assign hold_expired = 1'b0;
   assign timeout_err  = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      owner_nxt = owner_id;
      ptr_nxt   = ptr;
      wait_nxt  = wait_cnt;
      case (state)
         ST_IDLE, ST_RELEASE: begin
            grant_nxt = '0;
            state_nxt = ST_IDLE;
            if (any_req) begin
               grant_nxt[win] = 1'b1;
               owner_nxt      = win;
               wait_nxt       = '0;
               state_nxt      = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (owner_busy) begin
               state_nxt = ST_OWNED;
            end else if (!owner_req || (wait_cnt == WAIT_W'(ACK_WAIT - 1))) begin
               grant_nxt = '0;
               ptr_nxt   = owner_id;
               state_nxt = ST_IDLE;
            end else begin
               wait_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         ST_OWNED: begin
            if (!owner_busy || hold_expired) begin
               grant_nxt = '0;
               ptr_nxt   = owner_id;
               state_nxt = ST_RELEASE;
            end
         end
         default: begin
            grant_nxt = '0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ptr starts at the last slot so requester 0 is searched first
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         grant    <= '0;
         owner_id <= '0;
         ptr      <= IDW'(NREQ - 1);
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         grant    <= grant_nxt;
         owner_id <= owner_nxt;
         ptr      <= ptr_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   assign mem_en    = (state == ST_OWNED);
   assign mem_addr  = mem_en ? req_addr[32'(owner_id) * BUSADDRW +: BUSADDRW] : '0;
   assign mem_rd_wr = mem_en & req_rd_wr[owner_id];
   assign state_dbg = state;

   always_comb begin
      data_valid = '0;
      if (mem_en) begin
         data_valid[owner_id] = mem_data_valid;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations plus
// randomized requester agents, all checked every cycle against a behavioural model.
module tb_mem_bus_arbiter;

   localparam int NREQ     = 4;
   localparam int BUSADDRW = 32;
   localparam int IDW      = 2;
   localparam int ACK_WAIT = 4;
   localparam int MAX_HOLD = 64;
   localparam int N_RAND   = 3000;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [NREQ-1:0]          req, busy, req_rd_wr;
   logic [NREQ*BUSADDRW-1:0] req_addr;
   logic [NREQ-1:0]          grant, data_valid;
   logic [IDW-1:0]           owner_id;
   logic [BUSADDRW-1:0]      mem_addr;
   logic                     mem_rd_wr, mem_en, mem_data_valid, timeout_err;
   logic [1:0]               state_dbg;

   int n_vec = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   logic [IDW-1:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .NREQ     (NREQ),
      .BUSADDRW (BUSADDRW),
      .IDW      (IDW),
      .ACK_WAIT (ACK_WAIT),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .req            (req),
      .busy           (busy),
      .req_addr       (req_addr),
      .req_rd_wr      (req_rd_wr),
      .grant          (grant),
      .owner_id       (owner_id),
      .mem_addr       (mem_addr),
      .mem_rd_wr      (mem_rd_wr),
      .mem_en         (mem_en),
      .mem_data_valid (mem_data_valid),
      .data_valid     (data_valid),
      .timeout_err    (timeout_err),
      .state_dbg      (state_dbg)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Who holds an offer or the bus, how long, and who was served last.
   int m_oid, m_last, m_wait, m_hold, m_w;
   bit m_offered, m_holding, m_tmo;

   function automatic int pick(input logic [NREQ-1:0] r, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         if (r[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_oid = 0; m_last = NREQ - 1; m_wait = 0; m_hold = 0;
      m_offered = 1'b0; m_holding = 1'b0; m_tmo = 1'b0;
   endtask

   task automatic model_step();
      m_tmo = 1'b0;
      if (m_offered) begin
         m_wait++;
         if (busy[m_oid]) begin
            m_offered = 1'b0; m_holding = 1'b1; m_hold = 0;
         end else if (!req[m_oid] || m_wait >= ACK_WAIT) begin
            m_offered = 1'b0; m_last = m_oid;
         end
      end else if (m_holding) begin
         m_hold++;
         if (!busy[m_oid]) begin
            m_holding = 1'b0; m_last = m_oid;
         end
`ifdef MEM_ARB_TIMEOUT_EN
         else if (m_hold >= MAX_HOLD) begin
            m_holding = 1'b0; m_last = m_oid; m_tmo = 1'b1;
         end
`endif
      end else begin
         m_w = pick(req, m_last);
         if (m_w >= 0) begin
            m_offered = 1'b1; m_oid = m_w; m_wait = 0;
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) model_reset();
         else model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [NREQ-1:0]     e_grant, e_dv;
   logic [BUSADDRW-1:0] e_addr;
   logic                e_rw;

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (chk_en) begin
            e_grant = '0; e_dv = '0; e_addr = '0; e_rw = 1'b0;
            if (m_offered || m_holding) e_grant[m_oid] = 1'b1;
            if (m_holding) begin
               e_addr       = req_addr[m_oid * BUSADDRW +: BUSADDRW];
               e_rw         = req_rd_wr[m_oid];
               e_dv[m_oid]  = mem_data_valid;
            end
            check("m_grant", 32'(grant), 32'(e_grant));
            check("m_owner_id", 32'(owner_id), m_oid);
            check("m_mem_en", 32'(mem_en), 32'(m_holding));
            check("m_mem_addr", mem_addr, e_addr);
            check("m_mem_rd_wr", 32'(mem_rd_wr), 32'(e_rw));
            check("m_data_valid", 32'(data_valid), 32'(e_dv));
            check("m_timeout_err", 32'(timeout_err), 32'(m_tmo));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      reset = 1'b0;
      req = '0; busy = '0; mem_data_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_grant(output int who, output int polls);
      polls = 0;
      who   = -1;
      do begin
         @(negedge clk);
         #2;
         polls++;
      end while (grant == '0 && polls < 20);
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) who = i;
      end
   endtask

   task automatic serve(input int hold, output int who, output int polls);
      wait_grant(who, polls);
      if (who < 0) return;
      busy[who] = 1'b1;
      repeat (hold) @(negedge clk);
      #2 busy[who] = 1'b0;
   endtask

   // ---------------- random requester agents ----------------
   int  ack_dly[NREQ];
   int  job_left[NREQ];
   bit  in_job[NREQ];

   task automatic agents_step();
      req_addr       = {$urandom(), $urandom(), $urandom(), $urandom()};
      req_rd_wr      = 4'($urandom_range(0, 15));
      mem_data_valid = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NREQ; i++) begin
         if (in_job[i]) begin
            if (job_left[i] == 0) begin
               busy[i] = 1'b0; req[i] = 1'b0; in_job[i] = 1'b0;
            end else begin
               job_left[i]--;
            end
         end else if (grant[i]) begin
            busy[i] = 1'b0;
            if (ack_dly[i] == 0) begin
               busy[i] = 1'b1; in_job[i] = 1'b1;
               job_left[i] = $urandom_range(0, 6);
            end else begin
               ack_dly[i]--;
            end
            if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
         end else begin
            busy[i] = ($urandom_range(0, 7) == 0);
            if (!req[i] && $urandom_range(0, 3) == 0) begin
               req[i] = 1'b1;
               ack_dly[i] = $urandom_range(0, 5);
            end
         end
      end
   endtask

   // ---------------- main sequence ----------------
   int who, polls, cnt, run;
   bit got3, tmo_seen;
   logic [IDW-1:0] e_id;

   initial begin
      reset = 1'b0;
      req = '0; busy = '0; req_rd_wr = '0; mem_data_valid = 1'b0;
      req_addr = {$urandom(), $urandom(), $urandom(), $urandom()};
      repeat (2) @(negedge clk);
      #2;
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_owner_id", 32'(owner_id), 32'h0);
      check("rst_mem_en", 32'(mem_en), 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_rd_wr", 32'(mem_rd_wr), 32'h0);
      check("rst_data_valid", 32'(data_valid), 32'h0);
      check("rst_timeout_err", 32'(timeout_err), 32'h0);
      chk_en = 1'b1;
      reset  = 1'b1;

      // single requester, busy for 5 cycles
      @(negedge clk);
      req = 4'b0001;
      @(negedge clk);
      #2 check("t1_grant_latency", 32'(grant), 32'h1);
      busy = 4'b0001;
      cnt  = 0;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         #2;
         if (mem_en) cnt++;
         if (k == 4) begin busy = '0; req = '0; end
         if (k == 5) check("t1_release_gap", 32'({grant, 3'b000, mem_en}), 32'h0);
      end
      check("t1_owned_cycles", cnt, 5);
      req = 4'b0011;
      @(negedge clk);
      #2 check("t1_ptr_after_0", 32'(grant), 32'h2);
      req = '0;
      repeat (2) @(negedge clk);

      // all requesting, 3-cycle jobs
      do_reset();
      req = 4'b1111;
      exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      for (int n = 0; n < 5; n++) begin
         serve(3, who, polls);
         e_id = exp_q.pop_front();
         check("t2_order", who, 32'(e_id));
         if (n > 0) check("t2_dead_cycles", polls - 1, 1);
      end
      req = '0;
      repeat (3) @(negedge clk);

      // grantee never acknowledges
      do_reset();
      req  = 4'b1100;
      cnt  = 0;
      got3 = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #2;
         if (grant == 4'b0100) cnt++;
         else if (grant == 4'b1000) begin got3 = 1'b1; break; end
      end
      check("t3_ack_wait_cycles", cnt, 4);
      check("t3_next_is_3", 32'(got3), 32'h1);
      req = '0;
      repeat (3) @(negedge clk);

      // data steering to owner 1
      req_addr[1*BUSADDRW +: BUSADDRW] = 32'hA5A5_1234;
      req_rd_wr = 4'b1101;
      req = 4'b0010;
      wait_grant(who, polls);
      check("t4_owner", who, 1);
      busy = 4'b0010;
      cnt  = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         mem_data_valid = (k == 1 || k == 3 || k == 6);
         #3;
         check("t4_data_valid", 32'(data_valid),
               (k == 1 || k == 3 || k == 6) ? 32'h2 : 32'h0);
         if (data_valid == 4'b0010) cnt++;
         if (k == 0) begin
            check("t4_mem_addr", mem_addr, 32'hA5A5_1234);
            check("t4_mem_rd_wr", 32'(mem_rd_wr), 32'h0);
         end
      end
      check("t4_pulse_count", cnt, 3);
      mem_data_valid = 1'b0; busy = '0; req = '0;
      @(negedge clk);
      mem_data_valid = 1'b1;
      #3 check("t4_dv_not_owned", 32'(data_valid), 32'h0);
      mem_data_valid = 1'b0;
      repeat (2) @(negedge clk);

      // reset while requester 3 owns the bus
      do_reset();
      req = 4'b1000;
      wait_grant(who, polls);
      busy = 4'b1000;
      repeat (2) @(negedge clk);
      mem_data_valid = 1'b1;
      #1 check("t5_owned_before", 32'(mem_en), 32'h1);
      #2 reset = 1'b0;
      #1;
      check("t5_rst_grant", 32'(grant), 32'h0);
      check("t5_rst_mem_en", 32'(mem_en), 32'h0);
      check("t5_rst_data_valid", 32'(data_valid), 32'h0);
      busy = '0; req = 4'b1001; mem_data_valid = 1'b0;
      @(negedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      #2 check("t5_first_priority", 32'(grant), 32'h1);
      req = '0;
      repeat (3) @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
      // ownership exceeding MAX_HOLD
      do_reset();
      req = 4'b0001;
      wait_grant(who, polls);
      busy     = 4'b0001;
      run      = 0;
      tmo_seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         #2;
         if (mem_en) run++;
         else if (run > 0) begin
            tmo_seen = timeout_err;
            check("t6_owner_id", 32'(owner_id), 32'h0);
            break;
         end
      end
      check("t6_hold_cycles", run, MAX_HOLD);
      check("t6_timeout_pulse", 32'(tmo_seen), 32'h1);
      busy = '0; req = '0;
      @(negedge clk);
      #2 check("t6_pulse_one_cycle", 32'(timeout_err), 32'h0);
      repeat (2) @(negedge clk);
`endif

      // randomized traffic
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         ack_dly[i] = 0; job_left[i] = 0; in_job[i] = 1'b0;
      end
      for (int c = 0; c < N_RAND; c++) begin
         @(negedge clk);
         agents_step();
      end
      req = '0; busy = '0; mem_data_valid = 1'b0;
      repeat (4) @(negedge clk);
      #3;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
